// File: rtl/lc4_divider_iter_pkg.sv
// lc4_divider_iter_pkg
// Shared definitions for the iterative LC4 divider: FSM state encodings
// and the iteration count of one restoring divide.
package lc4_divider_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One quotient bit per iteration, so one iteration per operand bit.
  localparam int DIV_ITERS = 16;

  // Counter value seen on the final iteration (counter starts at 0).
  localparam logic [3:0] LAST_ITER = 4'(DIV_ITERS - 1);

endpackage

// File: rtl/cla16.sv
// cla16
// 16-bit carry-lookahead adder: four 4-bit lookahead groups whose group
// generate/propagate terms feed a second lookahead level for the group carries.
// Ports:
//   a, b  in  16  addends
//   cin   in  1   carry in
//   sum   out 16  a + b + cin (low 16 bits)
//   cout  out 1   carry out of bit 15
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g_s;
  logic [15:0] p_s;
  logic [3:0]  gg_s;
  logic [3:0]  gp_s;
  logic [16:0] c_s;

  // Bit and group generate/propagate, group carries, then in-group carries.
  always_comb begin
    g_s  = a & b;
    p_s  = a ^ b;
    gg_s = 4'd0;
    gp_s = 4'd0;
    c_s  = 17'd0;
    c_s[0] = cin;
    for (int k = 0; k < 4; k++) begin
      gp_s[k] = &p_s[4*k +: 4];
      gg_s[k] = g_s[4*k+3]
              | (p_s[4*k+3] & g_s[4*k+2])
              | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
              | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
    end
    for (int k = 0; k < 4; k++) begin
      c_s[4*k+4] = gg_s[k] | (gp_s[k] & c_s[4*k]);
    end
    for (int k = 0; k < 4; k++) begin
      c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & c_s[4*k]);
      c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
      c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
    end
    sum  = p_s ^ c_s[15:0];
    cout = c_s[16];
  end

endmodule

// File: rtl/lc4_divider_step.sv
// lc4_divider_step
// One combinational iteration of restoring division.
// Ports:
//   rem       in  16  partial remainder
//   dvd       in  16  dividend shift register (MSB is the next bit down)
//   dsr       in  16  divisor
//   rem_next  out 16  partial remainder after this iteration
//   dvd_next  out 16  dividend shifted left by one
//   qbit      out 1   quotient bit produced by this iteration
module lc4_divider_step (
  input  logic [15:0] rem,
  input  logic [15:0] dvd,
  input  logic [15:0] dsr,
  output logic [15:0] rem_next,
  output logic [15:0] dvd_next,
  output logic        qbit
);

  logic [16:0] trial_s;
  logic [15:0] diff_s;
  logic        no_borrow_s;
  logic        ge_s;

  assign trial_s  = {rem, dvd[15]};
  assign dvd_next = {dvd[14:0], 1'b0};

  // trial[15:0] - dsr as trial + ~dsr + 1; carry out is 1 when no borrow.
  cla16 u_sub (
    .a   (trial_s[15:0]),
    .b   (~dsr),
    .cin (1'b1),
    .sum (diff_s),
    .cout(no_borrow_s)
  );

  // 17-bit compare trial >= {0,dsr}: a set trial MSB already exceeds any
  // 16-bit divisor, otherwise the low-half borrow decides.
  always_comb begin
    ge_s = trial_s[16] | no_borrow_s;
    if (ge_s) begin
      rem_next = diff_s;
      qbit     = 1'b1;
    end else begin
      rem_next = trial_s[15:0];
      qbit     = 1'b0;
    end
  end

endmodule

// File: rtl/lc4_divider_iter.sv
// lc4_divider_iter
// Multi-cycle 16-bit unsigned divider (restoring, one quotient bit per cycle).
// A request is taken in IDLE, iterated 16 times in BUSY, and the result is
// presented with a one-cycle o_valid pulse in DONE. Divide by zero yields 0 r 0.
// Ports:
//   clk          in  1   clock, rising edge
//   rst          in  1   synchronous active-high reset
//   i_valid      in  1   request valid
//   i_ready      out 1   high exactly in IDLE
//   i_dividend   in  16  dividend, sampled on accept
//   i_divisor    in  16  divisor, sampled on accept
//   o_valid      out 1   one-cycle result pulse
//   o_quotient   out 16  quotient, held until next o_valid
//   o_remainder  out 16  remainder, held until next o_valid
module lc4_divider_iter
  import lc4_divider_iter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  state_t           state_r;
  logic [3:0]       cnt_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;

  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] dvd_next_s;
  logic             qbit_s;
  logic [WIDTH-1:0] quo_next_s;

  assign i_ready    = (state_r == ST_IDLE);
  assign quo_next_s = {quo_r[WIDTH-2:0], qbit_s};

  lc4_divider_step u_step (
    .rem     (rem_r),
    .dvd     (dvd_r),
    .dsr     (dsr_r),
    .rem_next(rem_next_s),
    .dvd_next(dvd_next_s),
    .qbit    (qbit_s)
  );

  // Divider FSM, iteration counter, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      dvd_r       <= '0;
      dsr_r       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      o_valid     <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          o_valid <= 1'b0;
          // i_ready is high in IDLE, so i_valid alone means accept here.
          if (i_valid) begin
            dvd_r   <= i_dividend;
            dsr_r   <= i_divisor;
            rem_r   <= '0;
            quo_r   <= '0;
            cnt_r   <= 4'd0;
            state_r <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          dvd_r <= dvd_next_s;
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == LAST_ITER) begin
            state_r <= ST_DONE;
            o_valid <= 1'b1;
            // Results come from this final iteration, not the stale registers.
            if (dsr_r == '0) begin
              o_quotient  <= '0;
              o_remainder <= '0;
            end else begin
              o_quotient  <= quo_next_s;
              o_remainder <= rem_next_s;
            end
          end else begin
            state_r <= ST_BUSY;
            o_valid <= 1'b0;
          end
        end
        ST_DONE: begin
          o_valid <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc4_divider_iter.sv
// tb_lc4_divider_iter
// Directed self-checking bench for lc4_divider_iter.
module tb_lc4_divider_iter;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] i_dividend;
  logic [15:0] i_divisor;
  logic        o_valid;
  logic [15:0] o_quotient;
  logic [15:0] o_remainder;

  int n_checks = 0;
  int n_fail   = 0;

  lc4_divider_iter #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_valid    (o_valid),
    .o_quotient (o_quotient),
    .o_remainder(o_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single divide: accept, count edges to o_valid, check result and handshake.
  task automatic do_div(input logic [15:0] dd, input logic [15:0] ds,
                        input logic [15:0] eq, input logic [15:0] er,
                        input string name);
    int got;
    int waited;
    bit ready_bad;
    waited = 0;
    while (!i_ready && waited < 40) begin
      tick();
      waited++;
    end
    n_checks++;
    if (i_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_wait: i_ready=%b required 1", name, i_ready);
    end
    i_dividend = dd;
    i_divisor  = ds;
    i_valid    = 1'b1;
    tick();
    i_valid    = 1'b0;
    i_dividend = 16'hDEAD;
    i_divisor  = 16'h0001;
    got = 0;
    ready_bad = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (i_ready) ready_bad = 1'b1;
      if (o_valid) begin
        got = n;
        break;
      end
    end
    n_checks++;
    if (got !== 16) begin
      n_fail++;
      $display("FAIL %s_latency: o_valid after %0d edges, required 16", name, got);
    end
    n_checks++;
    if (ready_bad !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_ready_busy: i_ready seen high during BUSY/DONE, required low", name);
    end
    n_checks++;
    if (o_quotient !== eq || o_remainder !== er) begin
      n_fail++;
      $display("FAIL %s_result: got %h r %h, required %h r %h",
               name, o_quotient, o_remainder, eq, er);
    end
    tick();
    n_checks++;
    if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_quotient !== eq || o_remainder !== er) begin
      n_fail++;
      $display("FAIL %s_after: o_valid=%b i_ready=%b q=%h r=%h, required 0 1 %h %h",
               name, o_valid, i_ready, o_quotient, o_remainder, eq, er);
    end
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b1;
    i_valid = 1'b0;
    i_dividend = 16'd0;
    i_divisor = 16'd0;
    tick();
    tick();
    // Request presented together with reset must be dropped.
    i_valid = 1'b1;
    i_dividend = 16'd77;
    i_divisor = 16'd7;
    tick();
    rst = 1'b0;
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_quotient !== 16'd0 || o_remainder !== 16'd0 || i_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: v=%b q=%h r=%h rdy=%b, required 0 0 0 1",
               o_valid, o_quotient, o_remainder, i_ready);
    end
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (o_valid || !i_ready) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req_dropped: activity seen=%b, required 0", seen);
    end
  endtask

  task automatic test_basic();
    do_div(16'd100, 16'd7, 16'd14, 16'd2, "d100_7");
    do_div(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, "dffff_1");
    do_div(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, "dffff_ffff");
    do_div(16'd3, 16'd10, 16'd0, 16'd3, "d3_10");
  endtask

  task automatic test_wide_compare();
    do_div(16'h8000, 16'hFFFF, 16'd0, 16'h8000, "d8000_ffff");
    do_div(16'hFFFE, 16'h8001, 16'd1, 16'h7FFD, "dfffe_8001");
  endtask

  task automatic test_div_zero();
    do_div(16'd1234, 16'd0, 16'd0, 16'd0, "d1234_0");
  endtask

  task automatic test_reset_midop();
    bit seen;
    i_dividend = 16'h1234;
    i_divisor  = 16'd3;
    i_valid    = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int n = 0; n < 8; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_quotient !== 16'd0 || o_remainder !== 16'd0 || i_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_reset_state: v=%b q=%h r=%h rdy=%b, required 0 0 0 1",
               o_valid, o_quotient, o_remainder, i_ready);
    end
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (o_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_no_valid: o_valid seen=%b, required 0", seen);
    end
    do_div(16'd50, 16'd5, 16'd10, 16'd0, "d50_5");
  endtask

  task automatic test_back_to_back();
    int cyc;
    int acc2;
    int nres;
    bit prev_ready;
    logic [15:0] q1, r1, q2, r2;
    i_dividend = 16'd9;
    i_divisor  = 16'd2;
    i_valid    = 1'b1;
    tick();
    nres = 0;
    acc2 = -1;
    q1 = 16'd0; r1 = 16'd0; q2 = 16'd0; r2 = 16'd0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      // Operand pair changes every cycle; only the IDLE-cycle pair is 21/4.
      if (i_ready) begin
        i_dividend = 16'd21;
        i_divisor  = 16'd4;
      end else begin
        i_dividend = 16'hABCD + 16'(cyc);
        i_divisor  = 16'd3;
      end
      prev_ready = i_ready;
      tick();
      if (prev_ready && acc2 < 0) acc2 = cyc;
      if (o_valid) begin
        nres++;
        if (nres == 1) begin
          q1 = o_quotient; r1 = o_remainder;
        end else begin
          q2 = o_quotient; r2 = o_remainder;
          i_valid = 1'b0;
          break;
        end
      end
    end
    i_valid = 1'b0;
    n_checks++;
    if (q1 !== 16'd4 || r1 !== 16'd1) begin
      n_fail++;
      $display("FAIL b2b_first: got %0d r %0d, required 4 r 1", q1, r1);
    end
    n_checks++;
    if (nres !== 2 || q2 !== 16'd5 || r2 !== 16'd1) begin
      n_fail++;
      $display("FAIL b2b_second: results=%0d got %0d r %0d, required 2 results, 5 r 1", nres, q2, r2);
    end
    n_checks++;
    if (acc2 < 0 || cyc - acc2 !== 16) begin
      n_fail++;
      $display("FAIL b2b_latency: second o_valid %0d edges after accept, required 16", cyc - acc2);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide_compare();
    test_div_zero();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
